// File: rtl/baud_tick_gen.sv
// Programmable baud-rate strobe generator: fractional oversample divider with
// mid-bit and bit-boundary strobes, hold, phase restart and shadowed reload.
module baud_tick_gen #(
  parameter int unsigned CNT_W        = 16,
  parameter int unsigned FRAC_W       = 4,
  parameter int unsigned OVERSAMPLE   = 16,
  parameter int unsigned DEFAULT_INT  = 108,
  parameter int unsigned DEFAULT_FRAC = 8
) (
  input  logic              system_clock,
  input  logic              rst,
  input  logic              enable,
  input  logic              sync_restart,
  input  logic              cfg_load,
  input  logic [CNT_W-1:0]  div_int,
  input  logic [FRAC_W-1:0] div_frac,
  output logic              os_tick,
  output logic              mid_tick,
  output logic              bit_tick,
  output logic              cfg_err
);

  localparam int unsigned OS_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);
  localparam logic [OS_W-1:0] OS_MID  = OS_W'(OVERSAMPLE / 2 - 1);

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [OS_W-1:0]   os_cnt_q, os_cnt_d;
  logic [FRAC_W-1:0] frac_acc_q, frac_acc_d;
  logic              carry_q, carry_d;
  logic [CNT_W-1:0]  act_int_q, act_int_d;
  logic [FRAC_W-1:0] act_frac_q, act_frac_d;
  logic [CNT_W-1:0]  sh_int_q, sh_int_d;
  logic [FRAC_W-1:0] sh_frac_q, sh_frac_d;
  logic              pend_q, pend_d;
  logic              err_q, err_d;
  logic              os_q, os_d;
  logic              mid_q, mid_d;
  logic              bit_q, bit_d;

  logic              load_ok;
  logic              load_bad;
  logic [CNT_W-1:0]  period_m1;
  logic [CNT_W-1:0]  nxt_int;
  logic [FRAC_W-1:0] nxt_frac;
  logic [FRAC_W:0]   frac_sum;

  // State register
  always_ff @(posedge system_clock or posedge rst) begin
    if (rst) begin
      cnt_q      <= '0;
      os_cnt_q   <= '0;
      frac_acc_q <= '0;
      carry_q    <= 1'b0;
      act_int_q  <= CNT_W'(DEFAULT_INT);
      act_frac_q <= FRAC_W'(DEFAULT_FRAC);
      sh_int_q   <= CNT_W'(DEFAULT_INT);
      sh_frac_q  <= FRAC_W'(DEFAULT_FRAC);
      pend_q     <= 1'b0;
      err_q      <= 1'b0;
      os_q       <= 1'b0;
      mid_q      <= 1'b0;
      bit_q      <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      os_cnt_q   <= os_cnt_d;
      frac_acc_q <= frac_acc_d;
      carry_q    <= carry_d;
      act_int_q  <= act_int_d;
      act_frac_q <= act_frac_d;
      sh_int_q   <= sh_int_d;
      sh_frac_q  <= sh_frac_d;
      pend_q     <= pend_d;
      err_q      <= err_d;
      os_q       <= os_d;
      mid_q      <= mid_d;
      bit_q      <= bit_d;
    end
  end

  // Next-state logic
  always_comb begin
    cnt_d      = cnt_q;
    os_cnt_d   = os_cnt_q;
    frac_acc_d = frac_acc_q;
    carry_d    = carry_q;
    act_int_d  = act_int_q;
    act_frac_d = act_frac_q;
    sh_int_d   = sh_int_q;
    sh_frac_d  = sh_frac_q;
    pend_d     = pend_q;
    err_d      = err_q;
    os_d       = 1'b0;
    mid_d      = 1'b0;
    bit_d      = 1'b0;

    load_ok   = cfg_load && (div_int >= CNT_W'(2));
    load_bad  = cfg_load && (div_int <  CNT_W'(2));
    period_m1 = act_int_q - CNT_W'(1) + CNT_W'(carry_q);

    // Divisor that governs the period starting after a wrap or restart
    if (load_ok) begin
      nxt_int  = div_int;
      nxt_frac = div_frac;
    end else if (pend_q) begin
      nxt_int  = sh_int_q;
      nxt_frac = sh_frac_q;
    end else begin
      nxt_int  = act_int_q;
      nxt_frac = act_frac_q;
    end
    frac_sum = {1'b0, frac_acc_q} + {1'b0, nxt_frac};

    if (load_bad) begin
      err_d = 1'b1;
    end else if (load_ok) begin
      err_d = 1'b0;
    end

    if (sync_restart) begin
      cnt_d      = '0;
      os_cnt_d   = '0;
      frac_acc_d = '0;
      carry_d    = 1'b0;
      act_int_d  = nxt_int;
      act_frac_d = nxt_frac;
      pend_d     = 1'b0;
    end else if (enable) begin
      // >= keeps a divisor shrunk during hold from running the counter around
      if (cnt_q >= period_m1) begin
        cnt_d      = '0;
        os_d       = 1'b1;
        frac_acc_d = frac_sum[FRAC_W-1:0];
        carry_d    = frac_sum[FRAC_W];
        act_int_d  = nxt_int;
        act_frac_d = nxt_frac;
        pend_d     = 1'b0;
        mid_d      = (os_cnt_q == OS_MID);
        if (os_cnt_q == OS_LAST) begin
          os_cnt_d = '0;
          bit_d    = 1'b1;
        end else begin
          os_cnt_d = os_cnt_q + OS_W'(1);
        end
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
        if (load_ok) begin
          sh_int_d  = div_int;
          sh_frac_d = div_frac;
          pend_d    = 1'b1;
        end
      end
    end else if (load_ok) begin
      act_int_d  = div_int;
      act_frac_d = div_frac;
      pend_d     = 1'b0;
    end
  end

  assign os_tick  = os_q;
  assign mid_tick = mid_q;
  assign bit_tick = bit_q;
  assign cfg_err  = err_q;

endmodule

// File: tb/tb_baud_tick_gen.sv
// Scoreboard bench for baud_tick_gen: a period-countdown reference model
// predicts every strobe time; a negedge monitor matches DUT strobes to it.
module tb_baud_tick_gen;

  localparam int unsigned CNT_W        = 16;
  localparam int unsigned FRAC_W       = 4;
  localparam int unsigned OVERSAMPLE   = 16;
  localparam int unsigned DEFAULT_INT  = 108;
  localparam int unsigned DEFAULT_FRAC = 8;
  localparam longint      HALF         = 5;
  localparam longint      PER          = 10;

  logic              system_clock = 1'b0;
  logic              rst          = 1'b0;
  logic              enable       = 1'b0;
  logic              sync_restart = 1'b0;
  logic              cfg_load     = 1'b0;
  logic [CNT_W-1:0]  div_int      = '0;
  logic [FRAC_W-1:0] div_frac     = '0;
  logic              os_tick, mid_tick, bit_tick, cfg_err;

  baud_tick_gen #(
    .CNT_W(CNT_W), .FRAC_W(FRAC_W), .OVERSAMPLE(OVERSAMPLE),
    .DEFAULT_INT(DEFAULT_INT), .DEFAULT_FRAC(DEFAULT_FRAC)
  ) dut (
    .system_clock(system_clock), .rst(rst), .enable(enable),
    .sync_restart(sync_restart), .cfg_load(cfg_load),
    .div_int(div_int), .div_frac(div_frac),
    .os_tick(os_tick), .mid_tick(mid_tick), .bit_tick(bit_tick),
    .cfg_err(cfg_err)
  );

  always #5 system_clock = ~system_clock;

  typedef struct {
    longint t;
    bit     mid;
    bit     bt;
  } ev_t;

  ev_t exp_q[$];

  int checks = 0;
  int errors = 0;
  int stim_timeouts = 0;
  bit end_req = 1'b0;
  bit end_done = 1'b0;
  int exp_os_iv = 0;
  int exp_bit_iv = 0;

  // Reference model: clocks left in the current oversample period
  int m_act_int  = DEFAULT_INT;
  int m_act_frac = DEFAULT_FRAC;
  int m_sh_int   = DEFAULT_INT;
  int m_sh_frac  = DEFAULT_FRAC;
  bit m_pend     = 1'b0;
  bit m_err      = 1'b0;
  int m_left     = DEFAULT_INT;
  int m_os       = 0;
  int m_acc      = 0;

  always @(posedge system_clock or posedge rst) begin
    if (rst) begin
      m_act_int = DEFAULT_INT; m_act_frac = DEFAULT_FRAC;
      m_sh_int = DEFAULT_INT;  m_sh_frac = DEFAULT_FRAC;
      m_pend = 1'b0; m_err = 1'b0;
      m_left = DEFAULT_INT; m_os = 0; m_acc = 0;
      exp_q.delete();
    end else begin
      bit ok, bad;
      int n_int, n_frac;
      ok  = cfg_load && (int'(div_int) >= 2);
      bad = cfg_load && (int'(div_int) < 2);
      if (bad) m_err = 1'b1;
      else if (ok) m_err = 1'b0;
      if (ok) begin n_int = int'(div_int); n_frac = int'(div_frac); end
      else if (m_pend) begin n_int = m_sh_int; n_frac = m_sh_frac; end
      else begin n_int = m_act_int; n_frac = m_act_frac; end
      if (sync_restart) begin
        m_act_int = n_int; m_act_frac = n_frac; m_pend = 1'b0;
        m_os = 0; m_acc = 0; m_left = m_act_int;
      end else if (enable) begin
        m_left = m_left - 1;
        if (m_left <= 0) begin
          ev_t e;
          e.t   = $time;
          e.mid = (m_os == OVERSAMPLE / 2 - 1);
          e.bt  = (m_os == OVERSAMPLE - 1);
          exp_q.push_back(e);
          m_os  = (m_os + 1) % OVERSAMPLE;
          m_acc = m_acc + n_frac;
          m_act_int = n_int; m_act_frac = n_frac; m_pend = 1'b0;
          m_left = m_act_int + ((m_acc >= (1 << FRAC_W)) ? 1 : 0);
          m_acc  = m_acc % (1 << FRAC_W);
        end else if (ok) begin
          m_sh_int = n_int; m_sh_frac = n_frac; m_pend = 1'b1;
        end
      end else if (ok) begin
        m_left = m_left + (n_int - m_act_int);
        m_act_int = n_int; m_act_frac = n_frac; m_pend = 1'b0;
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT strobes
  longint last_os_t = 0;
  longint last_bit_t = 0;

  always @(negedge system_clock) begin
    if (rst) begin
      checks++;
      if (os_tick || mid_tick || bit_tick || cfg_err) begin
        errors++;
        $display("FAIL reset_outputs os=%0b mid=%0b bit=%0b err=%0b required all 0",
                 os_tick, mid_tick, bit_tick, cfg_err);
      end
      last_os_t = 0;
      last_bit_t = 0;
    end else begin
      while (exp_q.size() > 0 && exp_q[0].t + HALF < $time) begin
        checks++; errors++;
        $display("FAIL missed_tick at %0t: no strobe observed, required strobe expected at %0t",
                 $time, exp_q[0].t + HALF);
        void'(exp_q.pop_front());
      end
      if (os_tick || mid_tick || bit_tick) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_tick at %0t os=%0b mid=%0b bit=%0b, required no strobe",
                   $time, os_tick, mid_tick, bit_tick);
        end else begin
          ev_t e;
          e = exp_q.pop_front();
          if (e.t + HALF != $time || !os_tick || mid_tick != e.mid || bit_tick != e.bt) begin
            errors++;
            $display("FAIL tick_match got t=%0t os=%0b mid=%0b bit=%0b required t=%0t os=1 mid=%0b bit=%0b",
                     $time, os_tick, mid_tick, bit_tick, e.t + HALF, e.mid, e.bt);
          end
        end
        if (os_tick) begin
          if (exp_os_iv != 0 && last_os_t != 0) begin
            checks++;
            if ($time - last_os_t != longint'(exp_os_iv) * PER) begin
              errors++;
              $display("FAIL os_interval got %0d clocks required %0d",
                       ($time - last_os_t) / PER, exp_os_iv);
            end
          end
          last_os_t = $time;
        end
        if (bit_tick) begin
          if (exp_bit_iv != 0 && last_bit_t != 0) begin
            checks++;
            if ($time - last_bit_t != longint'(exp_bit_iv) * PER) begin
              errors++;
              $display("FAIL bit_interval got %0d clocks required %0d",
                       ($time - last_bit_t) / PER, exp_bit_iv);
            end
          end
          last_bit_t = $time;
        end
      end
      checks++;
      if (cfg_err !== m_err) begin
        errors++;
        $display("FAIL cfg_err at %0t got %0b required %0b", $time, cfg_err, m_err);
      end
    end
    if (end_req && !end_done) begin
      checks++;
      if (exp_q.size() != 0 || stim_timeouts != 0) begin
        errors++;
        $display("FAIL end_state pending=%0d timeouts=%0d required 0 and 0",
                 exp_q.size(), stim_timeouts);
      end
      end_done = 1'b1;
    end
  end

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge system_clock);
      #1;
    end
  endtask

  // Wait for n DUT strobes (which: 0 = os, 1 = bit), bounded by limit clocks
  task automatic wait_ticks(input int which, input int n, input int limit);
    int seen = 0;
    for (int i = 0; i < limit && seen < n; i++) begin
      @(negedge system_clock);
      if ((which == 0) ? os_tick : bit_tick) seen++;
    end
    if (seen < n) begin
      stim_timeouts++;
      $display("timeout waiting for strobe kind %0d at %0t", which, $time);
    end
    step(1);
  endtask

  task automatic load(input int di, input int df);
    cfg_load = 1'b1;
    div_int  = CNT_W'(di);
    div_frac = FRAC_W'(df);
    step(1);
    cfg_load = 1'b0;
  endtask

  initial begin
    #1 rst = 1'b1;
    step(3);
    rst = 1'b0;
    step(1);
    enable = 1'b1;

    // Defaults: 108/109 alternation, 1736 clocks per bit
    wait_ticks(1, 1, 2000);
    exp_bit_iv = 1736;
    wait_ticks(1, 8, 16000);
    exp_bit_iv = 0;

    // Shadowed reload mid-period
    step(50);
    load(10, 0);
    wait_ticks(0, 2, 400);
    exp_os_iv = 10;
    wait_ticks(1, 1, 400);
    exp_bit_iv = 160;
    wait_ticks(1, 3, 600);
    exp_os_iv = 0;

    // Hold for 37 clocks inside one bit
    exp_bit_iv = 197;
    step(40);
    enable = 1'b0;
    step(37);
    enable = 1'b1;
    wait_ticks(1, 1, 400);
    exp_bit_iv = 0;

    // Restart on the edge that would produce a bit strobe, with a new divisor
    begin
      bit found = 1'b0;
      for (int i = 0; i < 400 && !found; i++) begin
        if (m_left == 1 && m_os == OVERSAMPLE - 1) found = 1'b1;
        else step(1);
      end
      if (!found) begin
        stim_timeouts++;
        $display("timeout waiting for bit wrap alignment");
      end
    end
    sync_restart = 1'b1;
    load(4, 0);
    sync_restart = 1'b0;
    wait_ticks(1, 1, 200);
    exp_bit_iv = 64;
    exp_os_iv  = 4;
    wait_ticks(1, 2, 200);
    exp_bit_iv = 0;
    exp_os_iv  = 0;

    // Illegal load sets the sticky error and changes nothing
    load(108, 8);
    wait_ticks(1, 2, 4000);
    load(1, 3);
    wait_ticks(1, 1, 2000);
    exp_bit_iv = 1736;
    wait_ticks(1, 2, 4000);
    exp_bit_iv = 0;
    load(2, 0);
    wait_ticks(0, 2, 300);
    exp_os_iv = 2;
    step(40);
    exp_os_iv = 0;

    // Randomized enable / load / restart traffic
    for (int i = 0; i < 3000; i++) begin
      enable       = ($urandom_range(99, 0) < 90);
      sync_restart = ($urandom_range(199, 0) == 0);
      cfg_load     = ($urandom_range(49, 0) == 0);
      div_int      = CNT_W'($urandom_range(12, 0));
      div_frac     = FRAC_W'($urandom_range(15, 0));
      step(1);
    end
    sync_restart = 1'b0;
    cfg_load     = 1'b0;
    enable       = 1'b1;
    step(20);

    // Asynchronous reset between edges, then power-up behaviour again
    @(posedge system_clock);
    #3 rst = 1'b1;
    step(2);
    rst    = 1'b0;
    enable = 1'b0;
    step(1);
    enable = 1'b1;
    wait_ticks(1, 1, 2000);
    exp_bit_iv = 1736;
    wait_ticks(1, 1, 2000);
    exp_bit_iv = 0;
    step(5);

    end_req = 1'b1;
    for (int i = 0; i < 10 && !end_done; i++) step(1);
    if (!end_done) begin
      $display("FAIL end_state monitor did not finish");
      $fatal(1);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
